// File: rtl/ppbuf_read_control.sv
// ppbuf_read_control: drain-side controller for the A/B ping-pong bit buffers.
// Banks are read in strict A/B alternation. Each bank is read from address 0 to
// BLOCK_LEN-1. The one-cycle RAM latency is covered by an in-flight tag stage.
// Bits are delivered serially through a 2-entry output FIFO. That FIFO is bypassed
// when empty, so the first bit appears in the same cycle its read data returns.
// Optional feature macro: PPBUF_OVERFLOW_DETECT_EN (sticky write-overrun flag).
module ppbuf_read_control #(
    parameter int BLOCK_LEN = 192,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              full_A,
    input  logic              full_B,
    output logic              rden_A,
    output logic              rden_B,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic              q_A,
    input  logic              q_B,
    output logic              valid_next,
    input  logic              ready_next,
    output logic              q,
    output logic              sob,
    output logic              eob,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {IDLE, READ_A, READ_B} state_t;

    state_t            state;
    logic              pend_A;
    logic              pend_B;
    logic              next_bank;     // 0 = bank A, 1 = bank B
    logic [ADDR_W-1:0] addr;

    // read-latency stage: tag of the read issued last cycle
    logic              vld_p1;
    logic              bank_p1;
    logic              sob_p1;
    logic              eob_p1;

    // output FIFO, entries are {bit, sob, eob}
    logic [1:0]        occ;
    logic [1:0]        occ_next;
    logic [2:0]        ent0;
    logic [2:0]        ent1;

    logic [2:0]        ret_ent;
    logic [2:0]        head;
    logic [2:0]        load;
    logic              pop;
    logic              issue;
    logic              last_issue;

    // Data returning from the RAM this cycle, tagged with its block markers
    assign ret_ent    = {(bank_p1 ? q_B : q_A), sob_p1, eob_p1};

    // The FIFO head is presented first; when the FIFO is empty the returning bit goes straight through
    assign valid_next = (occ != 2'd0) || vld_p1;
    assign head       = (occ != 2'd0) ? ent0 : (vld_p1 ? ret_ent : 3'b000);
    assign q          = head[2];
    assign sob        = head[1];
    assign eob        = head[0];
    assign pop        = valid_next & ready_next;

    // Credit check: FIFO entries plus the read in flight, less this cycle's pop, must stay below 2
    assign load       = {1'b0, occ} + {2'b00, vld_p1};
    assign issue      = (state != IDLE) && (load < (3'd2 + {2'b00, pop}));
    assign last_issue = issue && (addr == LAST_ADDR);
    assign rden_A     = issue && (state == READ_A);
    assign rden_B     = issue && (state == READ_B);
    assign rdaddress  = addr;

    assign occ_next   = occ + {1'b0, vld_p1} - {1'b0, pop};

    // Bank sequencing FSM: wait for the expected bank, sweep its addresses, then alternate
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= IDLE;
            next_bank <= 1'b0;
            addr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!next_bank && pend_A)
                        state <= READ_A;
                    else if (next_bank && pend_B)
                        state <= READ_B;
                end
                READ_A: begin
                    if (issue) begin
                        addr <= last_issue ? '0 : addr + 1'b1;
                        if (last_issue) begin
                            next_bank <= 1'b1;
                            state     <= pend_B ? READ_B : IDLE;
                        end
                    end
                end
                READ_B: begin
                    if (issue) begin
                        addr <= last_issue ? '0 : addr + 1'b1;
                        if (last_issue) begin
                            next_bank <= 1'b0;
                            state     <= pend_A ? READ_A : IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pending flags: a new full pulse wins over the clear on a bank's last issue
    always_ff @(posedge clk) begin
        if (!resetN) begin
            pend_A <= 1'b0;
            pend_B <= 1'b0;
        end else begin
            pend_A <= full_A | (pend_A & ~(last_issue && (state == READ_A)));
            pend_B <= full_B | (pend_B & ~(last_issue && (state == READ_B)));
        end
    end

    // Read-latency stage control: marks that a read result returns next cycle
    always_ff @(posedge clk) begin
        if (!resetN)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= issue;
    end

    // Read-latency stage data: bank and block markers of the read just issued
    always_ff @(posedge clk) begin
        if (issue) begin
            bank_p1 <= (state == READ_B);
            sob_p1  <= (addr == '0);
            eob_p1  <= (addr == LAST_ADDR);
        end
    end

    // Output FIFO occupancy
    always_ff @(posedge clk) begin
        if (!resetN)
            occ <= 2'd0;
        else
            occ <= occ_next;
    end

    // Output FIFO storage: shift on pop, append returning data unless it bypassed
    always_ff @(posedge clk) begin
        case (occ)
            2'd0: begin
                if (vld_p1 && !pop)
                    ent0 <= ret_ent;
            end
            2'd1: begin
                if (pop) begin
                    if (vld_p1)
                        ent0 <= ret_ent;
                end else if (vld_p1) begin
                    ent1 <= ret_ent;
                end
            end
            default: begin
                if (pop)
                    ent0 <= ent1;
            end
        endcase
    end

`ifdef PPBUF_OVERFLOW_DETECT_EN
    // Sticky overrun: a bank reported full again before its previous block was drained
    always_ff @(posedge clk) begin
        if (!resetN)
            overflow <= 1'b0;
        else if ((full_A && (pend_A || (state == READ_A))) ||
                 (full_B && (pend_B || (state == READ_B))))
            overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: doc/ppbuf_read_control.md
# ppbuf_read_control

Drain-side controller for the 192-bit ping-pong bit buffer pair (banks A and B) in the transmit chain. The write-side controller fills one bank while this block reads the other. This block tracks which banks are full and reads them in strict A/B alternation, including the one-cycle RAM read latency. It delivers the bits serially to the next stage over a valid/ready handshake, with start- and end-of-block markers.

## Interface
- BLOCK_LEN, 192, bits per bank (one block)
- ADDR_W, 8, read address width; must satisfy 2^ADDR_W >= BLOCK_LEN

- clk  in  1  single clock, all state updates on rising edge
- resetN  in  1  reset, synchronous, active-low
- full_A  in  1  one-cycle pulse from write side: bank A holds a complete block
- full_B  in  1  one-cycle pulse: bank B holds a complete block
- rden_A  out  1  read enable, bank A
- rden_B  out  1  read enable, bank B
- rdaddress  out  ADDR_W  shared read address, valid when rden_A or rden_B is high
- q_A  in  1  bank A read data, valid one cycle after rden_A
- q_B  in  1  bank B read data, valid one cycle after rden_B
- valid_next  out  1  q/sob/eob valid toward next stage
- ready_next  in  1  next stage accepts; transfer = valid_next & ready_next
- q  out  1  serial output bit
- sob  out  1  high with the first bit (address 0) of a block
- eob  out  1  high with the last bit (address BLOCK_LEN-1) of a block
- overflow  out  1  sticky write-overrun flag (see Configuration)

## Operation
- Pending flags pend_A and pend_B:
  - Set on the edge after a full_x pulse.
  - Cleared on the edge where address BLOCK_LEN-1 of that bank is issued.
- next_bank register: resets to A and toggles after each completed block issue. Banks are always drained A, B, A, B, …
- States:
  - IDLE: no reads. Go to READ_A or READ_B when pend of next_bank is set.
  - READ_A / READ_B: issue reads from addr 0 to BLOCK_LEN-1.
  - On the last issue, go to READ_other if pend_other is already set (registered value); otherwise go to IDLE.
- Read issue uses credit flow control. Issue this cycle iff occ + inflight − pop < 2, where:
  - occ = output FIFO occupancy (0..2);
  - inflight = a read was issued last cycle;
  - pop = valid_next & ready_next.
- On issue: rden_x=1, rdaddress=addr, addr increments. addr wraps to 0 after BLOCK_LEN-1.
- In-flight tag register holds {bank, sob, eob}. The next cycle, q_A or q_B (by bank tag) is pushed into a 2-entry output FIFO as {bit, sob, eob}.
- Output: valid_next = FIFO non-empty; q/sob/eob = FIFO head. Entries pop on transfer. Push and pop in the same cycle are allowed.
- The FIFO can never overflow: the credit rule guarantees it.
- A full pulse for a bank not yet expected waits in its pend flag. Order is never reordered.

## Timing
- Reset (resetN=0 at an edge) leaves the following state:
  - state IDLE, next_bank A, pend flags 0, addr 0, FIFO empty, inflight 0, overflow 0.
  - Outputs rden_A=rden_B=0, rdaddress=0, valid_next=q=sob=eob=0.
- Reset mid-block discards the partial block and in-flight data.
- Latency with ready_next held high, full_A pulse in cycle 0:
  - pend_A=1 in cycle 1;
  - READ_A and first rden_A (addr 0) in cycle 2;
  - valid_next with sob=1 in cycle 3.
- Throughput is 1 bit/cycle with ready_next high. If pend_B is set before A's last issue, B addr 0 is issued the cycle after A addr 191, with no bubble.
- With ready_next low, at most 2 reads are outstanding. Issue resumes the cycle ready_next returns high.
- rden_A and rden_B are never high together. Reads never target a bank whose pend flag is clear.

## Configuration
- PPBUF_OVERFLOW_DETECT_EN defined: overflow is set, and stays set until reset, when full_x pulses while pend_x is already 1 or while state is READ_x. The pend flag remains set and reading continues unchanged.
- Not defined: overflow is tied 0. No detection logic is compiled, and the port remains present.

## Test plan
- Single block, ready_next=1: full_A at cycle 0 → rden_A cycles 2–193, addresses 0..191; 192 transfers cycles 3–194, sob at the first, eob at the last; then IDLE.
- Back-to-back: full_A at 0, full_B at 100 → B addr 0 issued at cycle 194, valid_next continuously high cycles 3–386, eob at cycles 194 and 386.
- Backpressure: ready_next toggles 1/0 every cycle → output bit sequence equals the preloaded bank contents exactly, no drops or duplicates, and never more than 2 outstanding.
- Out-of-order: full_B before any full_A → no reads until full_A; then A is drained first, then B.
- Overflow (macro on): second full_A during READ_A → overflow=1 next cycle and stays 1 until resetN=0. With the macro off → overflow stays 0.
- Reset mid-block: resetN=0 at bit 50 → all outputs 0 next cycle; a fresh full_A restarts reading at A addr 0 with sob.
